uart_cmd_wrapper: RTL and testbench

Host-link front end of LA_dig, directly downstream of the host UART master on the RX line.
- Deserialises 8N1 UART bytes and pairs them (high byte first) into a 16-bit command for the command/config unit.
- Serialises 8-bit responses from the command unit back out on TX.
- Sits between the RX/TX pins and the command processor; runs on the 100MHz system clk.

---
 rtl/la_pkg.sv | 11 +
 rtl/uart_cmd_wrapper_rx.sv | 117 +++++++++++
 rtl/uart_cmd_wrapper.sv | 188 ++++++++++++++++++
 tb/tb_uart_cmd_wrapper.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/la_pkg.sv
// Shared types and defaults for the LA_dig host-link UART front end.
package la_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
    typedef enum logic {HIGH, LOW} pair_state_t;

    localparam int BAUD_DIV_DEFAULT = 108;
    localparam int FRAME_BITS       = 10;

endpackage

// File: rtl/uart_cmd_wrapper_rx.sv
// uart_rx_core: RX synchroniser, 8N1 receive FSM and baud counter.
// With UART_CMD_FRAME_CHK_EN a zero stop bit drops the byte and pulses stop_err.
module uart_rx_core
    import la_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT,
    parameter int HALF_DIV = BAUD_DIV / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       byte_rdy
`ifdef UART_CMD_FRAME_CHK_EN
    ,
    output logic       stop_err
`endif
);

    localparam int CNT_W = $clog2(BAUD_DIV + 1);

    rx_state_t        state_q, state_d;
    logic             rx_s1_q, rx_s2_q, rx_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             fall;
    logic             expire;
    logic             stop_sample;

    // Presetting to 1 keeps reset release from looking like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    assign fall   = rx_prev_q & ~rx_s2_q;
    assign expire = (cnt_q == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = START;
                    cnt_d   = CNT_W'(HALF_DIV);
                end
            end
            START: begin
                // A line back high at mid start bit was only a glitch.
                if (expire) begin
                    if (rx_s2_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        cnt_d   = CNT_W'(BAUD_DIV);
                        bit_d   = '0;
                    end
                end
            end
            DATA: begin
                if (expire) begin
                    shift_d = {rx_s2_q, shift_q[7:1]};
                    cnt_d   = CNT_W'(BAUD_DIV);
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (expire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign stop_sample = (state_q == STOP) && expire;
    assign rx_data     = shift_q;

    always_comb begin
`ifdef UART_CMD_FRAME_CHK_EN
        byte_rdy = stop_sample & rx_s2_q;
        stop_err = stop_sample & ~rx_s2_q;
`else
        byte_rdy = stop_sample;
`endif
    end

endmodule

// File: rtl/uart_cmd_wrapper.sv
// uart_cmd_wrapper: pairs received bytes into 16-bit commands and serialises responses.
// Optional UART_CMD_FRAME_CHK_EN adds stop-bit checking and the frame_err output.
module uart_cmd_wrapper
    import la_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT,
    parameter int HALF_DIV = BAUD_DIV / 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent,
    output logic        tx_busy
`ifdef UART_CMD_FRAME_CHK_EN
    ,
    output logic        frame_err
`endif
);

    localparam int CNT_W = $clog2(BAUD_DIV + 1);

    logic [7:0] rx_data;
    logic       byte_rdy;
    logic       stop_err;

    uart_rx_core #(
        .BAUD_DIV (BAUD_DIV),
        .HALF_DIV (HALF_DIV)
    ) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (RX),
        .rx_data  (rx_data),
        .byte_rdy (byte_rdy)
`ifdef UART_CMD_FRAME_CHK_EN
        ,
        .stop_err (stop_err)
`endif
    );

`ifndef UART_CMD_FRAME_CHK_EN
    assign stop_err = 1'b0;
`endif

    pair_state_t pair_q, pair_d;
    logic [7:0]  cmd_hi_q, cmd_hi_d;
    logic [15:0] cmd_q, cmd_d;
    logic        cmd_rdy_q, cmd_rdy_d;
    logic        frame_err_q, frame_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_q      <= HIGH;
            cmd_hi_q    <= '0;
            cmd_q       <= '0;
            cmd_rdy_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            pair_q      <= pair_d;
            cmd_hi_q    <= cmd_hi_d;
            cmd_q       <= cmd_d;
            cmd_rdy_q   <= cmd_rdy_d;
            frame_err_q <= frame_err_d;
        end
    end

    // A framing error abandons any half-received command.
    always_comb begin
        pair_d = pair_q;
        if (byte_rdy) begin
            pair_d = (pair_q == HIGH) ? LOW : HIGH;
        end
        if (stop_err) begin
            pair_d = HIGH;
        end
    end

    // Set beats clear when a pair completes in the acknowledge cycle.
    always_comb begin
        cmd_hi_d    = cmd_hi_q;
        cmd_d       = cmd_q;
        cmd_rdy_d   = cmd_rdy_q;
        frame_err_d = frame_err_q;
        if (clr_cmd_rdy) begin
            cmd_rdy_d   = 1'b0;
            frame_err_d = 1'b0;
        end
        if (byte_rdy) begin
            if (pair_q == HIGH) begin
                cmd_hi_d  = rx_data;
                cmd_rdy_d = 1'b0;
            end else begin
                cmd_d     = {cmd_hi_q, rx_data};
                cmd_rdy_d = 1'b1;
            end
        end
        if (stop_err) begin
            frame_err_d = 1'b1;
        end
    end

    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;
`ifdef UART_CMD_FRAME_CHK_EN
    assign frame_err = frame_err_q;
`else
    logic unused_frame_err;
    assign unused_frame_err = frame_err_q;
`endif

    tx_state_t        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]       tx_bit_q, tx_bit_d;
    logic [8:0]       tx_shift_q, tx_shift_d;
    logic             tx_q, tx_d;
    logic             resp_sent_q, resp_sent_d;
    logic             accept;
    logic             tx_expire;

    // Blocking on resp_sent_q defers a request landing on the completion pulse.
    assign accept    = (tx_state_q == TX_IDLE) && send_resp && !resp_sent_q;
    assign tx_expire = (tx_cnt_q == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '1;
            tx_q        <= 1'b1;
            resp_sent_q <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_q        <= tx_d;
            resp_sent_q <= resp_sent_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            TX_IDLE:  if (accept) tx_state_d = TX_SHIFT;
            TX_SHIFT: if (tx_expire && tx_bit_q == 4'(FRAME_BITS - 1)) tx_state_d = TX_IDLE;
            default:  tx_state_d = TX_IDLE;
        endcase
    end

    // The start bit goes straight to the line; the shifter holds resp and the stop bit.
    always_comb begin
        tx_cnt_d    = (tx_cnt_q != '0) ? tx_cnt_q - CNT_W'(1) : tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        tx_d        = tx_q;
        resp_sent_d = 1'b0;
        if (accept) begin
            tx_shift_d = {1'b1, resp};
            tx_d       = 1'b0;
            tx_cnt_d   = CNT_W'(BAUD_DIV);
            tx_bit_d   = '0;
        end else if (tx_state_q == TX_SHIFT && tx_expire) begin
            if (tx_bit_q == 4'(FRAME_BITS - 1)) begin
                tx_d        = 1'b1;
                resp_sent_d = 1'b1;
            end else begin
                tx_d       = tx_shift_q[0];
                tx_shift_d = {1'b1, tx_shift_q[8:1]};
                tx_bit_d   = tx_bit_q + 4'd1;
                tx_cnt_d   = CNT_W'(BAUD_DIV);
            end
        end
    end

    always_comb begin
        tx_busy   = (tx_state_q == TX_SHIFT);
        TX        = tx_q;
        resp_sent = resp_sent_q;
    end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Directed self-checking bench for uart_cmd_wrapper (define UART_CMD_FRAME_CHK_EN to test frame checking).
module tb_uart_cmd_wrapper;

    localparam int BAUD = 108;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RX;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        resp_sent;
    logic        tx_busy;
`ifdef UART_CMD_FRAME_CHK_EN
    logic        frame_err;
`endif

    int checkCount = 0;
    int errorCount = 0;

    uart_cmd_wrapper dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .send_resp   (send_resp),
        .resp_sent   (resp_sent),
        .tx_busy     (tx_busy)
`ifdef UART_CMD_FRAME_CHK_EN
        ,
        .frame_err   (frame_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one 8N1 frame starting at a negedge; optionally probes cmd_rdy around the stop sample.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input logic doTiming,
                                 input logic expBefore, input logic expAfter);
        logic [9:0] frame;
        frame = {stopBit, data, 1'b0};
        for (int b = 0; b < 10; b++) begin
            RX = frame[b];
            if (b == 9 && doTiming) begin
                repeat (52) @(negedge clk);
                checkOutput("rdyBeforeStop", cmd_rdy, expBefore);
                repeat (8) @(negedge clk);
                checkOutput("rdyAfterStop", cmd_rdy, expAfter);
                repeat (BAUD - 60) @(negedge clk);
            end else begin
                repeat (BAUD) @(negedge clk);
            end
        end
        RX = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic pulseClear();
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic pulseReset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [9:0] txFrame;
        logic       seen;

        rst_n       = 1'b0;
        RX          = 1'b1;
        clr_cmd_rdy = 1'b0;
        resp        = 8'h00;
        send_resp   = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rstTX", TX, 1);
        checkOutput("rstCmd", cmd, 16'h0000);
        checkOutput("rstCmdRdy", cmd_rdy, 0);
        checkOutput("rstRespSent", resp_sent, 0);
        checkOutput("rstTxBusy", tx_busy, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        applyStimulus(8'h0A, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h5C, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("cmd0A5C", cmd, 16'h0A5C);
        repeat (50) @(negedge clk);
        checkOutput("rdySticky", cmd_rdy, 1);
        pulseClear();
        checkOutput("rdyCleared", cmd_rdy, 0);

        applyStimulus(8'h12, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h34, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("cmd1234", cmd, 16'h1234);
        applyStimulus(8'hAB, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("cmdHeldOnHigh", cmd, 16'h1234);
        applyStimulus(8'hCD, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("cmdABCD", cmd, 16'hABCD);

        pulseClear();
        RX = 1'b0;
        repeat (20) @(negedge clk);
        RX = 1'b1;
        repeat (300) @(negedge clk);
        checkOutput("glitchNoRdy", cmd_rdy, 0);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("cmd0001", cmd, 16'h0001);
        checkOutput("rdy0001", cmd_rdy, 1);

        txFrame = {1'b1, 8'hA5, 1'b0};
        resp = 8'hA5;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        for (int k = 0; k <= 1082; k++) begin
            if (k % BAUD == BAUD / 2 && k < 1080) checkOutput("txBit", TX, txFrame[k / BAUD]);
            if (k == 0) checkOutput("txBusyStart", tx_busy, 1);
            if (k == 107) checkOutput("txStartLast", TX, 0);
            if (k == 108) checkOutput("txBit0First", TX, 1);
            if (k == 500) begin
                resp = 8'hFF;
                send_resp = 1'b1;
            end
            if (k == 501) send_resp = 1'b0;
            if (k == 1079) begin
                checkOutput("respSentEarly", resp_sent, 0);
                checkOutput("busyBeforeEnd", tx_busy, 1);
            end
            if (k == 1080) begin
                checkOutput("respSentPulse", resp_sent, 1);
                checkOutput("busyDropped", tx_busy, 0);
                resp = 8'h3C;
                send_resp = 1'b1;
            end
            if (k == 1081) begin
                checkOutput("respSentOneCycle", resp_sent, 0);
                checkOutput("sendOnPulseIgnored", tx_busy, 0);
            end
            if (k == 1082) begin
                checkOutput("sendNextAccepted", tx_busy, 1);
                send_resp = 1'b0;
            end
            @(negedge clk);
        end
        seen = 1'b0;
        for (int k = 0; k < 1200 && !seen; k++) begin
            if (resp_sent) seen = 1'b1;
            @(negedge clk);
        end
        checkOutput("secondRespSent", seen, 1);

        pulseClear();
        applyStimulus(8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (200) @(negedge clk);
        applyStimulus(8'h44, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef UART_CMD_FRAME_CHK_EN
        checkOutput("frameErrSet", frame_err, 1);
        checkOutput("cmdAfterErr", cmd, 16'h4455);
        checkOutput("rdyAfterErr", cmd_rdy, 1);
        pulseClear();
        checkOutput("frameErrCleared", frame_err, 0);
`else
        checkOutput("cmdNoChk", cmd, 16'h3344);
        checkOutput("rdyNoChk", cmd_rdy, 0);
`endif

        pulseReset();
        applyStimulus(8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
        pulseReset();
        checkOutput("cmdAfterRst", cmd, 16'h0000);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h42, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("cmd0042", cmd, 16'h0042);
        checkOutput("rdy0042", cmd_rdy, 1);

        resp = 8'h00;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        repeat (200) @(negedge clk);
        checkOutput("txLowMidFrame", TX, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("txAsyncRst", TX, 1);
        checkOutput("busyAsyncRst", tx_busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
